// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//
// Bundles the pipeline-side request/response signals and the D-cache
// req/ack bus of the load/store unit.
//
// Handshake: dmem_req rises when the unit enters its request state. It stays
// high, with dmem_we/dmem_addr/dmem_wdata/dmem_wstrb stable, until the first
// cycle where dmem_ack is sampled high on a rising clock edge. That cycle
// completes the transfer, and dmem_ack may already be high in the first
// dmem_req cycle. dmem_ack seen while dmem_req is low is ignored.
//
// Modports:
//   master - the load/store unit (drives the memory request and the
//            pipeline responses)
//   slave  - the surrounding pipeline/memory environment
//
// Signals:
//   mem_read, mem_write, funct3, addr, store_data  pipeline request
//   stall, done, load_data, error                  pipeline response
//   dmem_req, dmem_we, dmem_addr, dmem_wdata,
//   dmem_wstrb                                     memory request
//   dmem_rdata, dmem_ack                           memory response
//   dbg_state                                      FSM state (0 IDLE, 1 REQ, 2 DONE)
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           store_data;

    logic                  stall;
    logic                  done;
    logic [31:0]           load_data;
    logic                  error;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_wdata;
    logic [3:0]            dmem_wstrb;
    logic [31:0]           dmem_rdata;
    logic                  dmem_ack;

    logic [1:0]            dbg_state;

    modport master (
        input  mem_read, mem_write, funct3, addr, store_data,
        input  dmem_rdata, dmem_ack,
        output stall, done, load_data, error,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dbg_state
    );

    modport slave (
        output mem_read, mem_write, funct3, addr, store_data,
        output dmem_rdata, dmem_ack,
        input  stall, done, load_data, error,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dbg_state
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// This is the data-memory side of the pipeline. It takes a load or store
// request from decode/EX and turns it into a single req/ack transfer to the
// D-cache. For a store it places the data in the correct byte lanes. For a
// load it returns the sign- or zero-extended result. The pipeline is stalled
// while an access is outstanding, and done pulses for one cycle when the
// access completes.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - load_store_unit_if.master (pipeline request/response, D-cache bus,
//           debug state)
//
// Build option:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses and the
//   undefined funct3 codes (011, 110, 111) complete immediately with
//   error=1 and no memory access. When undefined, nothing traps: the low
//   address bits are truncated to the access size, and unknown funct3 codes
//   act as W.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q;
    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [31:0]           load_data_q;
    logic                  done_q;
    logic                  error_q;

    // Request decode (IDLE-side next values)
    logic                  req_valid;
    logic                  we_d;
    logic [1:0]            size_d;
    logic [1:0]            off_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           wdata_d;
    logic [3:0]            wstrb_d;
    logic                  illegal_d;

    // Read-data extraction (REQ-side next value)
    logic [31:0]           rdata_shift;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [31:0]           load_data_d;

    assign req_valid = bus.mem_read | bus.mem_write;
    // A write takes priority when both request lines are set.
    assign we_d      = bus.mem_write;
    // Bit 2 of funct3 only selects the sign, so bits [1:0] give the size.
    // Codes 10 and 11 both act as W.
    assign size_d    = bus.funct3[1:0];
    assign off_d     = bus.addr[1:0];
    assign addr_d    = {bus.addr[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        wdata_d = bus.store_data;
        wstrb_d = 4'b1111;
        case (size_d)
            2'b00: begin
                wdata_d = {4{bus.store_data[7:0]}};
                wstrb_d = 4'b0001 << off_d;
            end
            2'b01: begin
                // addr[0] is dropped here; in a trapping build it has
                // already been rejected.
                wdata_d = {2{bus.store_data[15:0]}};
                wstrb_d = 4'b0011 << {off_d[1], 1'b0};
            end
            default: begin
                wdata_d = bus.store_data;
                wstrb_d = 4'b1111;
            end
        endcase
        if (!we_d) begin
            wstrb_d = 4'b0000;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        illegal_d = 1'b0;
        if (bus.funct3 == 3'b011 || bus.funct3 == 3'b110 || bus.funct3 == 3'b111) begin
            illegal_d = 1'b1;
        end else if (size_d == 2'b01 && off_d[0]) begin
            illegal_d = 1'b1;
        end else if (size_d == 2'b10 && off_d != 2'b00) begin
            illegal_d = 1'b1;
        end
    end
`else
    assign illegal_d = 1'b0;
`endif

    always_comb begin
        rdata_shift = bus.dmem_rdata >> {off_q, 3'b000};
        rbyte       = rdata_shift[7:0];
        rhalf       = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_data_d = {{24{~funct3_q[2] & rbyte[7]}}, rbyte};
            2'b01:   load_data_d = {{16{~funct3_q[2] & rhalf[15]}}, rhalf};
            default: load_data_d = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal_d) begin
                            // A rejected access skips the memory and
                            // completes on the next cycle.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q  <= REQ;
                            req_q    <= 1'b1;
                            we_q     <= we_d;
                            addr_q   <= addr_d;
                            wdata_q  <= wdata_d;
                            wstrb_q  <= wstrb_d;
                            funct3_q <= bus.funct3;
                            off_q    <= off_d;
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_ack) begin
                        if (!we_q) begin
                            load_data_q <= load_data_d;
                        end
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Any request still visible here belongs to the
                    // instruction that just completed.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // In IDLE the stall must rise in the same cycle the request appears.
    // An asserted reset forces it low straight away.
    assign bus.stall      = ((state_q == IDLE) && req_valid && !reset) || req_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.load_data  = load_data_q;
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.dmem_wstrb = wstrb_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit for the data-memory side of the pipeline. It consumes the `mem_read` / `mem_write` request produced by instruction decode, plus the `funct3` size field, the ALU address and the rs2 store data. It drives a req/ack handshake to the D-cache and returns sign- or zero-extended load data. The pipeline stalls while an access is outstanding.

## Interface
- `ADDR_WIDTH`, 32: byte address width on both pipeline and memory sides.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `mem_read`  in  1: load request from decode/EX; held stable while `stall`=1.
- `mem_write`  in  1: store request; if both `mem_read` and `mem_write` are set, `mem_write` wins.
- `funct3`  in  3: access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  ADDR_WIDTH: byte address (ALU result).
- `store_data`  in  32: rs2 value, data in low bits.
- `stall`  out  1: freeze pipeline.
- `done`  out  1: one-cycle pulse, access complete.
- `load_data`  out  32: extended load result, registered.
- `error`  out  1: misaligned/illegal access, valid with `done`.
- `dmem_req`  out  1: memory request, held until ack.
- `dmem_we`  out  1: 1 = write.
- `dmem_addr`  out  ADDR_WIDTH: word-aligned address (`[1:0]` = 0).
- `dmem_wdata`  out  32: lane-replicated store data.
- `dmem_wstrb`  out  4: byte enables (0 on reads).
- `dmem_rdata`  in  32: read word, valid with `dmem_ack`.
- `dmem_ack`  in  1: completes the request; may arrive in the first `dmem_req` cycle.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If `mem_read|mem_write` is high: `stall`=1 combinationally.
  - If the access is legal: latch `we`, `funct3`, `addr[1:0]`, word address, wdata and wstrb, then go to REQ.
  - If the access is illegal (see Configuration): go to DONE with `error` set, and issue no `dmem_req`.
- REQ:
  - `dmem_req`=1, `stall`=1; all `dmem_*` outputs are driven from the latched registers.
  - On `dmem_ack`: for a read, capture the extracted and extended `dmem_rdata` into `load_data`. Then go to DONE.
- DONE:
  - `done`=1, `stall`=0, `dmem_req`=0; the pipeline advances on this edge.
  - Next state is IDLE unconditionally; requests still visible during DONE are the completed instruction and are ignored.
- Lane selection uses offset `o=addr[1:0]`:
  - B: lane `o`, strobe `1<<o`, wdata `{4{sd[7:0]}}`.
  - H: lanes `o[1]*2..+1`, strobe `4'b0011<<(o[1]*2)`, wdata `{2{sd[15:0]}}`.
  - W: strobe 1111, wdata `sd`.
- Load extension: B and H sign-extend from bit 7 or 15; BU and HU zero-extend; W passes through.
- `funct3` 011, 110, 111 are illegal.
- `load_data` holds its value until the next completed read. Stores and errors leave it unchanged.
- `error` is 0 except in DONE after an illegal access.

## Timing
- Reset (async, any state): state IDLE; all outputs 0, including `load_data`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb`.
- Reset during REQ drops `dmem_req` immediately. The memory side must tolerate an abandoned request.
- Latency from request seen to the `done` pulse is 2 + N cycles, where N = cycles with `dmem_req`=1 before `dmem_ack`. Minimum is 2: IDLE, REQ with ack, DONE.
- Illegal access: IDLE then DONE, 1 cycle of `stall`.
- Back-to-back accesses: the next request is first seen in IDLE, one cycle after DONE. Throughput is at most one access per 3 cycles.
- `dmem_ack` outside REQ is ignored.
- `dmem_*` outputs are stable from REQ entry until ack.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H with `addr[0]`=1, W with `addr[1:0]`≠0, or an illegal `funct3` is rejected: no memory access, `error`=1 with `done`.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No access is illegal and `error` is tied 0.
  - Misaligned offsets are truncated: H ignores `addr[0]`, W ignores `addr[1:0]`.
  - Illegal `funct3` is treated as W.

## Test plan
- LB at 0x103, ack in first REQ cycle, `dmem_rdata`=0x80FF1234 → `dmem_addr`=0x100, `done` at cycle 2, `load_data`=0xFFFFFF80, `stall` high for 2 cycles.
- LHU at 0x102, ack after 3 wait cycles, rdata 0xBEEF0000 → `load_data`=0x0000BEEF, `done` at cycle 5, `dmem_req` held stable for 4 cycles.
- SH at 0x102, `store_data`=0x1234ABCD → `dmem_we`=1, `dmem_wstrb`=1100, `dmem_wdata`=0xABCDABCD; `load_data` unchanged.
- LW at 0x101 with `LSU_MISALIGN_TRAP_EN` → no `dmem_req`, `done`=`error`=1 at cycle 1. Without the macro → `dmem_addr`=0x100, `error`=0.
- Assert `reset` during REQ with an ack pending → state IDLE, `dmem_req`/`stall`/`done` = 0 immediately. A following SW at 0x200 completes normally.
- `mem_read`=`mem_write`=1, SB at 0x7 with `store_data`=0x55 → write, `dmem_wstrb`=1000, `dmem_wdata`=0x55555555.
